// File: rtl/matrix_cfg_pkg.sv
// Shared constants, side codes, state encoding and entry-order offsets for the matrix config loader.
package matrix_cfg_pkg;
    localparam int          ENTRY_W   = 6;
    localparam logic [7:0]  SYNC_WORD = 8'hA5;
    localparam int          N_ENTRIES = 18;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    // Entry index of the first pin of each side on cfg_bus.
    localparam int TOP_BASE    = 0;
    localparam int BOTTOM_BASE = 5;
    localparam int LEFT_BASE   = 10;
    localparam int RIGHT_BASE  = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_COMMIT,
        ST_ERROR
    } state_e;
endpackage

// File: rtl/matrix_cfg_entry_chk.sv
// Combinational legality check of one route entry against the per-side pin counts.
module matrix_cfg_entry_chk
    import matrix_cfg_pkg::*;
(
    input  logic [ENTRY_W-1:0] entry,
    input  logic [3:0]         n_tb,
    input  logic [3:0]         n_lr,
    output logic               illegal
);
    logic [2:0] side;
    logic [3:0] idx;

    assign side = entry[2:0];
    assign idx  = {1'b0, entry[ENTRY_W-1:3]};

    always_comb begin
        illegal = 1'b0;
        case (side)
            SIDE_NONE:              illegal = 1'b0;
            SIDE_TOP, SIDE_BOTTOM:  illegal = (idx >= n_tb);
            SIDE_RIGHT, SIDE_LEFT:  illegal = (idx >= n_lr);
            default:                illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/matrix_cfg_loader.sv
// Framed serial loader for the switch matrix route set; commits atomically on a clean frame.
// Optional per-entry even parity bit enabled with `define CFG_PARITY_EN.
module matrix_cfg_loader #(
    parameter int         N_TB      = 5,
    parameter int         N_LR      = 4,
    parameter int         ENTRY_W   = matrix_cfg_pkg::ENTRY_W,
    parameter logic [7:0] SYNC_WORD = matrix_cfg_pkg::SYNC_WORD
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_start,
    input  logic                                cfg_bit,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    output logic [ENTRY_W*(2*N_TB+2*N_LR)-1:0]  cfg_bus,
    output logic                                cfg_done,
    output logic                                cfg_err,
    output logic                                busy
);
    import matrix_cfg_pkg::*;

    localparam int N_ENT = 2*N_TB + 2*N_LR;
    localparam int BUS_W = ENTRY_W*N_ENT;

    state_e             state, state_nx;
    logic [7:0]         shreg, sh_nx;
    logic [2:0]         bit_cnt;
    logic [4:0]         ent_cnt;
    logic [BUS_W-1:0]   shadow, bus_q;
    logic               done_q;
    logic               acc, ent_bad, data_last, unit_last, ent_final;
    logic [ENTRY_W-1:0] ent_nx;

    // A start in the same cycle as a valid bit drops the bit.
    assign acc       = cfg_valid && cfg_ready && !cfg_start;
    assign sh_nx     = {shreg[6:0], cfg_bit};
    assign ent_nx    = sh_nx[ENTRY_W-1:0];
    assign data_last = (bit_cnt == 3'(ENTRY_W-1));
    assign ent_final = (ent_cnt == 5'(N_ENT-1));
`ifdef CFG_PARITY_EN
    logic par_bad;
    assign unit_last = (bit_cnt == 3'(ENTRY_W));
    assign par_bad   = ^{shreg[ENTRY_W-1:0], cfg_bit};
`else
    assign unit_last = data_last;
`endif

    matrix_cfg_entry_chk u_chk (
        .entry   (ent_nx),
        .n_tb    (4'(N_TB)),
        .n_lr    (4'(N_LR)),
        .illegal (ent_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        case (state)
            ST_SYNC: begin
                cfg_ready = 1'b1;
                if (acc && bit_cnt == 3'd7)
                    state_nx = (sh_nx == SYNC_WORD) ? ST_LOAD : ST_ERROR;
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                if (acc) begin
                    if (data_last && ent_bad)
                        state_nx = ST_ERROR;
`ifdef CFG_PARITY_EN
                    else if (unit_last && par_bad)
                        state_nx = ST_ERROR;
`endif
                    else if (unit_last && ent_final)
                        state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: state_nx = ST_IDLE;
            ST_IDLE, ST_ERROR: state_nx = state;
            default:   state_nx = ST_IDLE;
        endcase
        if (cfg_start) state_nx = ST_SYNC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            ent_cnt <= '0;
            shadow  <= '0;
        end else if (cfg_start) begin
            shreg   <= '0;
            bit_cnt <= '0;
            ent_cnt <= '0;
            shadow  <= '0;
        end else if (acc) begin
            shreg <= sh_nx;
            if (state == ST_SYNC) begin
                bit_cnt <= (bit_cnt == 3'd7) ? 3'd0 : bit_cnt + 3'd1;
            end else begin
                if (data_last)
                    shadow[32'(ent_cnt)*ENTRY_W +: ENTRY_W] <= ent_nx;
                if (unit_last) begin
                    bit_cnt <= '0;
                    ent_cnt <= ent_cnt + 5'd1;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_COMMIT && !cfg_start) begin
                bus_q  <= shadow;
                done_q <= 1'b1;
            end
        end
    end

    assign cfg_bus  = bus_q;
    assign cfg_done = done_q;
    assign cfg_err  = (state == ST_ERROR);
    assign busy     = (state != ST_IDLE) && (state != ST_ERROR);
endmodule

// File: tb/tb_matrix_cfg_loader.sv
// Directed scoreboard bench for matrix_cfg_loader; commit/error events are checked by a monitor.
module tb_matrix_cfg_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [107:0] cfg_bus;
    logic         cfg_done;
    logic         cfg_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           is_err;
        logic [107:0] bus;
    } exp_t;
    exp_t sb[$];

    logic [5:0]   ents [18];
    logic [7:0]   sync_b = 8'hA5;
    logic [107:0] expb;
    logic [107:0] prevb;
    logic         err_q = 1'b0;

    matrix_cfg_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_bus   (cfg_bus),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input bit is_err, input logic [107:0] bus);
        exp_t e;
        e.is_err = is_err;
        e.bus    = bus;
        sb.push_back(e);
    endtask

    task automatic mon_pop(input bit is_err);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got event err=%0d with nothing expected", is_err);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 108'(is_err), 108'(e.is_err));
            chk("sb_bus", cfg_bus, e.bus);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_done) mon_pop(1'b0);
            if (cfg_err && !err_q) mon_pop(1'b1);
        end
        err_q = cfg_err;
    end

    // All stimulus tasks begin and end on a falling edge.
    task automatic send_bit(input logic b, input bit gaps);
        int n;
        if (gaps) begin
            cfg_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        cfg_bit   = b;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got cfg_ready=0 required 1");
        end else begin
            @(negedge clk);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps, input int bad_par, input bit trunc);
        logic p;
        for (int i = 7; i >= 0; i--) send_bit(sync_b[i], gaps);
        for (int e = 0; e < n; e++) begin
            for (int b = 5; b >= 0; b--) send_bit(ents[e][b], gaps);
`ifdef CFG_PARITY_EN
            p = ^ents[e];
            if (e == bad_par) p = ~p;
            if (!(trunc && e == n-1)) send_bit(p, gaps);
`else
            p = 1'b0;
            if (bad_par >= 0 && trunc && p) $display("unused");
`endif
        end
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    function automatic logic [107:0] pack_ents();
        logic [107:0] r;
        r = '0;
        for (int e = 0; e < 18; e++) r[6*e +: 6] = ents[e];
        return r;
    endfunction

    task automatic clear_ents();
        for (int e = 0; e < 18; e++) ents[e] = 6'd0;
    endtask

    task automatic check_commit(input string nm, input logic [107:0] bus);
        chk({nm, "_done_early"}, 108'(cfg_done), 108'd0);
        @(negedge clk);
        chk({nm, "_done"}, 108'(cfg_done), 108'd1);
        chk({nm, "_bus"}, cfg_bus, bus);
        chk({nm, "_err"}, 108'(cfg_err), 108'd0);
        @(negedge clk);
        chk({nm, "_done_clr"}, 108'(cfg_done), 108'd0);
        chk({nm, "_busy_clr"}, 108'(busy), 108'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ents();
        repeat (3) @(negedge clk);
        chk("rst_bus", cfg_bus, 108'd0);
        chk("rst_ready", 108'(cfg_ready), 108'd0);
        chk("rst_done", 108'(cfg_done), 108'd0);
        chk("rst_err", 108'(cfg_err), 108'd0);
        chk("rst_busy", 108'(busy), 108'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame: right[2] on top0, everything else unconnected.
        ents[0] = 6'b010_010;
        pulse_start();
        chk("good_ready", 108'(cfg_ready), 108'd1);
        chk("good_busy", 108'(busy), 108'd1);
        push(1'b0, 108'h12);
        send_frame(18, 1'b0, -1, 1'b0);
        check_commit("good", 108'h12);

        // Bits offered while idle are ignored.
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        chk("idle_ready", 108'(cfg_ready), 108'd0);
        cfg_valid = 1'b0;

        // Bad sync word.
        sync_b = 8'hA4;
        pulse_start();
        push(1'b1, 108'h12);
        send_frame(0, 1'b0, -1, 1'b0);
        chk("badsync_err", 108'(cfg_err), 108'd1);
        chk("badsync_ready", 108'(cfg_ready), 108'd0);
        chk("badsync_bus", cfg_bus, 108'h12);
        sync_b = 8'hA5;

        // left0 sourcing top[5]: index out of range.
        clear_ents();
        ents[10] = 6'b101_001;
        pulse_start();
        chk("ill1_errclr", 108'(cfg_err), 108'd0);
        push(1'b1, 108'h12);
        send_frame(11, 1'b0, -1, 1'b1);
        chk("ill1_err", 108'(cfg_err), 108'd1);
        chk("ill1_ready", 108'(cfg_ready), 108'd0);
        @(negedge clk);
        chk("ill1_nodone", 108'(cfg_done), 108'd0);

        // Reserved side code 5.
        ents[10] = 6'd0;
        ents[11] = 6'b000_101;
        pulse_start();
        push(1'b1, 108'h12);
        send_frame(12, 1'b0, -1, 1'b1);
        chk("ill2_err", 108'(cfg_err), 108'd1);
        chk("ill2_bus", cfg_bus, 108'h12);

        // Mixed legal entries incl. self-loop (left3 <- left3), with valid gaps.
        clear_ents();
        ents[0]  = 6'b010_010;
        ents[5]  = 6'b100_001;
        ents[13] = 6'b011_100;
        ents[17] = 6'b001_011;
        expb = 108'h12;
        expb[35:30]   = 6'b100_001;
        expb[83:78]   = 6'b011_100;
        expb[107:102] = 6'b001_011;
        pulse_start();
        push(1'b0, expb);
        send_frame(18, 1'b1, -1, 1'b0);
        check_commit("gaps", expb);
        prevb = expb;

        // Abort at entry 7; restart pulse coincides with a valid bit which must be dropped.
        for (int e = 0; e < 18; e++) ents[e] = 6'b000_001;
        pulse_start();
        send_frame(7, 1'b0, -1, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("abort_err", 108'(cfg_err), 108'd0);
        chk("abort_ready", 108'(cfg_ready), 108'd1);
        chk("abort_bus", cfg_bus, prevb);
        clear_ents();
        ents[14] = 6'b010_010;
        ents[9]  = 6'b000_011;
        expb = '0;
        expb[89:84] = 6'b010_010;
        expb[59:54] = 6'b000_011;
        push(1'b0, expb);
        send_frame(18, 1'b0, -1, 1'b0);
        check_commit("restart", expb);

`ifdef CFG_PARITY_EN
        clear_ents();
        ents[3] = 6'b001_001;
        pulse_start();
        push(1'b1, expb);
        send_frame(4, 1'b0, 3, 1'b0);
        chk("par_err", 108'(cfg_err), 108'd1);
        chk("par_bus", cfg_bus, expb);
        pulse_start();
        push(1'b0, 108'(6'b001_001) << 18);
        send_frame(18, 1'b0, -1, 1'b0);
        check_commit("par_ok", 108'(6'b001_001) << 18);
`endif

        // Reset in the middle of a frame.
        pulse_start();
        send_frame(5, 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", cfg_bus, 108'd0);
        chk("mid_rst_ready", 108'(cfg_ready), 108'd0);
        chk("mid_rst_done", 108'(cfg_done), 108'd0);
        chk("mid_rst_err", 108'(cfg_err), 108'd0);
        chk("mid_rst_busy", 108'(busy), 108'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_empty", 108'(sb.size()), 108'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
